interrupt_controller: RTL
=========================

# interrupt_controller

Prioritised, maskable interrupt controller for the 8-bit CPU. Synchronises device interrupt lines, latches edges as pending requests and raises a single request to the control unit only at an instruction boundary (the control word END bit). It also supplies a 16-bit service vector, disables further interrupts while one is in service, and re-enables them on return from interrupt.

## Interface

Parameters:
- NUM_IRQ, 4, number of interrupt sources (1–8); index 0 has highest priority.
- VEC_BASE, 16'h0040, vector address of source 0.
- VEC_STRIDE, 16'h0008, vector spacing between sources.

Ports:
- clk  in  1  system clock; all state changes on rising edge.
- rst_n  in  1  reset, asynchronous, active-low.
- irq_in  in  NUM_IRQ  asynchronous device lines; a rising edge requests service.
- ctrl_end  in  1  END bit of the current control word; high means an instruction boundary this cycle.
- ie_set  in  1  EI strobe; sets the global enable.
- ie_clr  in  1  DI strobe; clears the global enable.
- mask_wr  in  1  writes mask_data into the mask register.
- mask_data  in  NUM_IRQ  per-source enable; 1 means enabled.
- int_ack  in  1  one-cycle pulse from the control unit when it begins the interrupt microsequence.
- iret  in  1  one-cycle pulse at completion of the return-from-interrupt instruction.
- int_req  out  1  interrupt request to the control unit.
- vector  out  16  service address; valid while int_req is high.
- pending  out  NUM_IRQ  latched, unserviced requests.
- in_service  out  1  high from ack until iret.

## Operation

- Each irq_in line passes through a 2-flop synchroniser and then an edge-detect flop. A synchronised 0→1 transition sets pending[i]. Level-high alone does nothing.
- Eligible set = pending & mask. The winner is the lowest eligible index.
- Global enable (ie) is a flop:
  - ie_clr beats ie_set in the same cycle.
  - ack clears ie.
  - iret sets ie.
- FSM states: IDLE, REQ, SERVICE.
  - IDLE → REQ when ie=1, the eligible set is non-zero and ctrl_end=1, all sampled in the same cycle. The winner index is latched into sel.
  - REQ: int_req=1 and vector = VEC_BASE + sel·VEC_STRIDE, computed mod 2^16.
    - On int_ack: clear pending[sel], clear ie, go to SERVICE.
    - On ie_clr without int_ack: withdraw and return to IDLE; pending is untouched.
    - If int_ack and ie_clr occur together, ack wins.
    - sel stays frozen in REQ even if a higher-priority request or a mask write arrives. Re-arbitration happens only after the next IDLE evaluation.
  - SERVICE: in_service=1, int_req=0. On iret: set ie and go to IDLE. Other requests stay pending (no nesting).
- A new edge on pending[sel] in the same cycle as the ack clear leaves the bit set: set beats clear.
- mask_wr takes effect on the next cycle. Masked sources still latch pending.
- iret in IDLE or REQ: only sets ie, with no state change.
- int_ack outside REQ is ignored.
- Reset (any time, including mid-service):
  - State → IDLE; pending, sel and ie → 0; mask → 0; synchroniser and edge flops → 0.
  - Outputs: int_req=0, vector=VEC_BASE, pending=0, in_service=0.

## Timing

- irq_in high before clk edge k (with 0 in the prior sample) → pending[i]=1 after edge k+2: 3-cycle latency.
- Eligible request plus ctrl_end=1 in cycle c → int_req=1 from cycle c+1. Vector is valid in the same cycle as int_req.
- int_ack sampled in cycle a → int_req=0, in_service=1 and pending[sel]=0 from cycle a+1.
- iret in cycle r → in_service=0 and ie=1 from r+1. A new request can then be raised at the first ctrl_end from r+1 onward, giving int_req at r+2 at the earliest.
- All outputs are registered except vector, which is combinational from sel.

## Test plan

- Reset, then mask=4'b1111 with ie_set. Pulse irq_in[2] → pending=4'b0100 three cycles later. With ctrl_end, int_req=1 next cycle and vector=16'h0050. After ack: pending=0, in_service=1.
- irq_in[3] and irq_in[1] rise together, boundary reached → vector=16'h0048. After ack and iret, the next boundary gives vector=16'h0058.
- mask=4'b1110 and irq_in[0] pulsed → pending[0]=1, int_req stays 0 across 10 boundaries. Writing mask=4'b0001 then makes int_req=1 at the next boundary.
- In REQ, ie_clr with no ack → int_req drops next cycle and pending is unchanged. Repeat with ie_clr and int_ack in the same cycle → enters SERVICE.
- In SERVICE, pulse irq_in[0] → int_req stays 0 until iret. After iret, int_req=1 at the next boundary.
- Assert rst_n=0 mid-SERVICE for one cycle → all outputs at reset values immediately. ie=0 after release, so no request is raised even with pending edges.

Source files
------------

// File: rtl/interrupt_controller_if.sv
// Interrupt controller bus: device lines, control-unit strobes and the
// request/vector/status returned by the controller.
//   master : CPU control unit / device side, drives lines and strobes
//   slave  : interrupt controller, drives int_req, vector, pending, in_service
interface interrupt_controller_if #(
    parameter int unsigned NUM_IRQ = 4
);
    logic [NUM_IRQ-1:0] irq_in;
    logic               ctrl_end;
    logic               ie_set;
    logic               ie_clr;
    logic               mask_wr;
    logic [NUM_IRQ-1:0] mask_data;
    logic               int_ack;
    logic               iret;
    logic               int_req;
    logic [15:0]        vector;
    logic [NUM_IRQ-1:0] pending;
    logic               in_service;

    modport master (
        output irq_in, ctrl_end, ie_set, ie_clr, mask_wr, mask_data, int_ack, iret,
        input  int_req, vector, pending, in_service
    );

    modport slave (
        input  irq_in, ctrl_end, ie_set, ie_clr, mask_wr, mask_data, int_ack, iret,
        output int_req, vector, pending, in_service
    );
endinterface

// File: rtl/interrupt_controller.sv
// Prioritised, maskable interrupt controller. Synchronises device lines,
// latches rising edges as pending requests and raises int_req to the control
// unit only at an instruction boundary (ctrl_end). Lowest index wins.
// Ports:
//   clk, rst_n : clock, asynchronous active-low reset
//   bus        : interrupt_controller_if.slave (lines, strobes, request,
//                vector, pending, in_service)
module interrupt_controller #(
    parameter int unsigned NUM_IRQ    = 4,
    parameter logic [15:0] VEC_BASE   = 16'h0040,
    parameter logic [15:0] VEC_STRIDE = 16'h0008
) (
    input  logic                   clk,
    input  logic                   rst_n,
    interrupt_controller_if.slave  bus
);

    localparam int unsigned SEL_W = (NUM_IRQ > 1) ? $clog2(NUM_IRQ) : 1;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        REQ     = 2'd1,
        SERVICE = 2'd2
    } state_e;

    state_e             state_q, state_d;
    logic [NUM_IRQ-1:0] sync1_q, sync1_d;
    logic [NUM_IRQ-1:0] sync2_q, sync2_d;
    logic [NUM_IRQ-1:0] edge_q, edge_d;
    logic [NUM_IRQ-1:0] pending_q, pending_d;
    logic [NUM_IRQ-1:0] mask_q, mask_d;
    logic [SEL_W-1:0]   sel_q, sel_d;
    logic               ie_q, ie_d;
    logic               int_req_q, int_req_d;
    logic               in_service_q, in_service_d;

    logic [NUM_IRQ-1:0] rise;
    logic [NUM_IRQ-1:0] eligible;
    logic [NUM_IRQ-1:0] ack_clr;
    logic [SEL_W-1:0]   winner;

    // Two-flop synchroniser followed by the edge-detect flop
    always_comb begin
        sync1_d = bus.irq_in;
        sync2_d = sync1_q;
        edge_d  = sync2_q;
        rise    = sync2_q & ~edge_q;
    end

    // Fixed priority: lowest eligible index wins
    always_comb begin
        eligible = pending_q & mask_q;
        winner   = '0;
        for (int i = int'(NUM_IRQ) - 1; i >= 0; i--) begin
            if (eligible[i]) begin
                winner = SEL_W'(i);
            end
        end
    end

    // Next-state, enable, mask and pending update
    always_comb begin
        state_d = state_q;
        sel_d   = sel_q;
        ie_d    = ie_q;
        mask_d  = mask_q;
        ack_clr = '0;

        if (bus.mask_wr) begin
            mask_d = bus.mask_data;
        end

        if (bus.iret || bus.ie_set) begin
            ie_d = 1'b1;
        end

        case (state_q)
            IDLE: begin
                if (ie_q && (|eligible) && bus.ctrl_end) begin
                    state_d = REQ;
                    sel_d   = winner;
                end
            end
            REQ: begin
                // sel is frozen here; ack takes precedence over a withdraw
                if (bus.int_ack) begin
                    ack_clr = NUM_IRQ'(1) << sel_q;
                    state_d = SERVICE;
                end else if (bus.ie_clr) begin
                    state_d = IDLE;
                end
            end
            SERVICE: begin
                if (bus.iret) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        // Clears beat sets: DI over EI/iret, and ack disables nesting
        if (bus.ie_clr || ((state_q == REQ) && bus.int_ack)) begin
            ie_d = 1'b0;
        end

        // A fresh edge on the acknowledged source survives the ack clear
        pending_d    = (pending_q & ~ack_clr) | rise;
        int_req_d    = (state_d == REQ);
        in_service_d = (state_d == SERVICE);
    end

    // State registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            sync1_q      <= '0;
            sync2_q      <= '0;
            edge_q       <= '0;
            pending_q    <= '0;
            mask_q       <= '0;
            sel_q        <= '0;
            ie_q         <= 1'b0;
            int_req_q    <= 1'b0;
            in_service_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            sync1_q      <= sync1_d;
            sync2_q      <= sync2_d;
            edge_q       <= edge_d;
            pending_q    <= pending_d;
            mask_q       <= mask_d;
            sel_q        <= sel_d;
            ie_q         <= ie_d;
            int_req_q    <= int_req_d;
            in_service_q <= in_service_d;
        end
    end

    assign bus.int_req    = int_req_q;
    assign bus.in_service = in_service_q;
    assign bus.pending    = pending_q;
    // Vector is decoded straight from sel, wrapping at 16 bits
    assign bus.vector     = VEC_BASE + VEC_STRIDE * 16'(sel_q);

endmodule
